// File: rtl/mod1_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mod1_sched_pkg                                               |
// | Description : Shared FSM state type and datapath widths for mod1_sched.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package mod1_sched_pkg;

    localparam int OPND_W = 3;
    localparam int RES_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mod1_sched_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rr_arbiter                                                   |
// | Description : Round-robin one-hot grant; search starts just after i_ptr.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [ID_W-1:0]  o_idx,
    output logic             o_any
);

    int   w_pos;
    logic w_found;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_pos   = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_pos = (int'(i_ptr) + k) % N_REQ;
            if (!w_found && i_req[w_pos]) begin
                w_found        = 1'b1;
                o_grant[w_pos] = 1'b1;
                o_idx          = ID_W'(w_pos);
            end
        end
    end

    assign o_any = w_found;

endmodule
`default_nettype wire

// File: rtl/mod1_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mod1_sched                                                   |
// | Description : Round-robin time-sharing of one external mod1 datapath.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mod1_sched
    import mod1_sched_pkg::*;
#(
    parameter  int N_REQ      = 4,
    parameter  int SETTLE_CYC = 2,
    localparam int ID_W       = $clog2(N_REQ)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [N_REQ-1:0]        REQ_V,
    output logic [N_REQ-1:0]        REQ_RDY,
    input  logic [N_REQ-1:0]        REQ_FLAG,
    input  logic [OPND_W*N_REQ-1:0] REQ_OPND,
    output logic                    M_IB1,
    output logic [OPND_W-1:0]       M_IV2_2,
    input  logic [RES_W-1:0]        M_OV1_3,
    output logic                    RSP_V,
    output logic [ID_W-1:0]         RSP_ID,
    output logic [RES_W-1:0]        RSP_DATA,
    input  logic                    RSP_ACK,
    output logic                    BUSY
);

    localparam int c_cnt_w = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC);
    localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(SETTLE_CYC - 1);

    if (SETTLE_CYC < 1) begin : g_bad_settle
        $error("mod1_sched: SETTLE_CYC must be at least 1");
    end
    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
        $error("mod1_sched: N_REQ must be within 2..8");
    end

    state_t               r_state;
    state_t               w_next;
    logic [ID_W-1:0]      r_ptr;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_ib1;
    logic [OPND_W-1:0]    r_iv2;
    logic                 r_rsp_v;
    logic [ID_W-1:0]      r_rsp_id;
    logic [RES_W-1:0]     r_rsp_data;

    logic [N_REQ-1:0]     w_grant;
    logic [ID_W-1:0]      w_idx;
    logic                 w_any;
    logic                 w_flag;
    logic [OPND_W-1:0]    w_opnd;
    logic                 w_accept;
    logic                 w_capture;
    logic                 w_release;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .i_req   (REQ_V),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // Grant is one-hot, so an OR-of-selected mux picks the winner's payload.
    always_comb begin
        w_flag = 1'b0;
        w_opnd = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) begin
                w_flag = REQ_FLAG[i];
                w_opnd = REQ_OPND[i*OPND_W +: OPND_W];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_capture = 1'b0;
        w_release = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_accept = 1'b1;
                    w_next   = SETTLE;
                end
            end
            SETTLE: begin
                if (r_cnt == '0) begin
                    w_capture = 1'b1;
                    w_next    = RESP;
                end
            end
            RESP: begin
                if (RSP_ACK) begin
                    w_release = 1'b1;
                    w_next    = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ptr      <= ID_W'(N_REQ - 1);
            r_cnt      <= '0;
            r_ib1      <= 1'b0;
            r_iv2      <= '0;
            r_rsp_v    <= 1'b0;
            r_rsp_id   <= '0;
            r_rsp_data <= '0;
        end else begin
            if (w_accept) begin
                r_ib1    <= w_flag;
                r_iv2    <= w_opnd;
                r_rsp_id <= w_idx;
                r_ptr    <= w_idx;
                r_cnt    <= c_cnt_init;
            end
            if (r_state == SETTLE && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
            if (w_capture) begin
                r_rsp_data <= M_OV1_3;
                r_rsp_v    <= 1'b1;
            end
            if (w_release) r_rsp_v <= 1'b0;
        end
    end

    assign REQ_RDY  = (r_state == IDLE) ? w_grant : '0;
    assign M_IB1    = r_ib1;
    assign M_IV2_2  = r_iv2;
    assign RSP_V    = r_rsp_v;
    assign RSP_ID   = r_rsp_id;
    assign RSP_DATA = r_rsp_data;
    assign BUSY     = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mod1_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mod1_sched                                                |
// | Description : Self-checking bench for mod1_sched (SETTLE_CYC 2 and 1).     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mod1_sched;

    localparam logic [11:0] c_opnd = 12'b111_101_011_001;

    logic       CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        rst;
    logic [3:0]  req_v, req_flag;
    logic [11:0] req_opnd;
    logic        ack;

    logic [3:0]  rdy      [2];
    logic        ib1      [2];
    logic [2:0]  iv2      [2];
    logic [3:0]  ov       [2];
    logic        rsp_v    [2];
    logic [1:0]  rsp_id   [2];
    logic [3:0]  rsp_data [2];
    logic        busy     [2];

    // mod1 stand-in: result is simply the concatenated inputs.
    assign ov[0] = {ib1[0], iv2[0]};
    assign ov[1] = {ib1[1], iv2[1]};

    mod1_sched #(.N_REQ(4), .SETTLE_CYC(2)) dut (
        .CLK(CLK), .RST(rst), .REQ_V(req_v), .REQ_RDY(rdy[0]), .REQ_FLAG(req_flag),
        .REQ_OPND(req_opnd), .M_IB1(ib1[0]), .M_IV2_2(iv2[0]), .M_OV1_3(ov[0]),
        .RSP_V(rsp_v[0]), .RSP_ID(rsp_id[0]), .RSP_DATA(rsp_data[0]),
        .RSP_ACK(ack), .BUSY(busy[0])
    );

    mod1_sched #(.N_REQ(4), .SETTLE_CYC(1)) dut_s1 (
        .CLK(CLK), .RST(rst), .REQ_V(req_v), .REQ_RDY(rdy[1]), .REQ_FLAG(req_flag),
        .REQ_OPND(req_opnd), .M_IB1(ib1[1]), .M_IV2_2(iv2[1]), .M_OV1_3(ov[1]),
        .RSP_V(rsp_v[1]), .RSP_ID(rsp_id[1]), .RSP_DATA(rsp_data[1]),
        .RSP_ACK(ack), .BUSY(busy[1])
    );

    int n_cmp = 0;
    int n_bad = 0;
    int m_settle [2] = '{2, 1};

    task automatic chk(input string name, input int inst, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (dut%0d): got 0x%0h, want 0x%0h", name, inst, act, exp);
        end
    endtask

    task automatic edge_();
        @(posedge CLK);
        #1;
    endtask

    task automatic reset_all();
        rst = 1'b1; req_v = '0; ack = 1'b0;
        edge_();
        edge_();
        rst = 1'b0;
    endtask

    // Round-robin rule: first requester found going upward from last winner + 1.
    function automatic int pick(input int last, input logic [3:0] rv);
        for (int k = 1; k <= 4; k++) begin
            if (rv[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    typedef struct {
        logic [3:0] rv;
        logic [3:0] fl;
        int         id;
        logic [3:0] data;
        int         hold;
    } vec_t;

    vec_t tbl [10];

    // Transaction-level reference: in-flight flag plus cycles since accept.
    bit         m_busy [2];
    int         m_age  [2];
    int         m_last [2];
    int         m_id   [2];
    logic       m_ib1  [2];
    logic [2:0] m_iv2  [2];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req_v = '0; req_flag = '0; req_opnd = '0; ack = 1'b0;
        tbl[0] = '{4'b0100, 4'b0100, 2, 4'hD, 10};
        tbl[1] = '{4'b1111, 4'b1000, 3, 4'hF, 0};
        tbl[2] = '{4'b1111, 4'b1000, 0, 4'h1, 1};
        tbl[3] = '{4'b1111, 4'b0010, 1, 4'hB, 0};
        tbl[4] = '{4'b1010, 4'b0000, 3, 4'h7, 2};
        tbl[5] = '{4'b0011, 4'b0001, 0, 4'h9, 0};
        tbl[6] = '{4'b0011, 4'b0001, 1, 4'h3, 0};
        tbl[7] = '{4'b1001, 4'b1111, 3, 4'hF, 0};
        tbl[8] = '{4'b0001, 4'b1111, 0, 4'h9, 0};
        tbl[9] = '{4'b1000, 4'b0111, 3, 4'h7, 0};

        reset_all();
        #3;
        for (int i = 0; i < 2; i++) begin
            chk("rst_rsp_v", i, int'(rsp_v[i]), 0);
            chk("rst_busy", i, int'(busy[i]), 0);
            chk("rst_m_ib1", i, int'(ib1[i]), 0);
            chk("rst_m_iv2", i, int'(iv2[i]), 0);
            chk("rst_rsp_id", i, int'(rsp_id[i]), 0);
            chk("rst_rsp_data", i, int'(rsp_data[i]), 0);
            chk("rst_rdy", i, int'(rdy[i]), 0);
        end
        edge_();

        // Directed grant/latency/backpressure table on the SETTLE_CYC=2 build.
        for (int e = 0; e < 10; e++) begin
            logic [3:0] fl;
            fl = tbl[e].fl;
            req_v = tbl[e].rv; req_flag = fl; req_opnd = c_opnd;
            #3;
            chk("idle_busy", 0, int'(busy[0]), 0);
            chk("grant", 0, int'(rdy[0]), 1 << tbl[e].id);
            edge_();
            req_v = 4'b1000; req_flag = ~fl; req_opnd = ~c_opnd;
            for (int s = 0; s < 2; s++) begin
                #3;
                chk("settle_rsp_v", 0, int'(rsp_v[0]), 0);
                chk("settle_rdy", 0, int'(rdy[0]), 0);
                chk("settle_busy", 0, int'(busy[0]), 1);
                chk("settle_m_ib1", 0, int'(ib1[0]), int'(fl[tbl[e].id]));
                chk("settle_m_iv2", 0, int'(iv2[0]), 2 * tbl[e].id + 1);
                edge_();
            end
            #3;
            chk("resp_v", 0, int'(rsp_v[0]), 1);
            chk("resp_id", 0, int'(rsp_id[0]), tbl[e].id);
            chk("resp_data", 0, int'(rsp_data[0]), int'(tbl[e].data));
            for (int h = 0; h < tbl[e].hold; h++) begin
                edge_();
                req_v = 4'b1111;
                #3;
                chk("hold_v", 0, int'(rsp_v[0]), 1);
                chk("hold_id", 0, int'(rsp_id[0]), tbl[e].id);
                chk("hold_data", 0, int'(rsp_data[0]), int'(tbl[e].data));
                chk("hold_rdy", 0, int'(rdy[0]), 0);
                chk("hold_busy", 0, int'(busy[0]), 1);
                chk("hold_m_iv2", 0, int'(iv2[0]), 2 * tbl[e].id + 1);
            end
            ack = 1'b1;
            edge_();
            ack = 1'b0; req_v = '0;
            #3;
            chk("ack_busy", 0, int'(busy[0]), 0);
            chk("ack_rsp_v", 0, int'(rsp_v[0]), 0);
            chk("ack_m_iv2_kept", 0, int'(iv2[0]), 2 * tbl[e].id + 1);
            edge_();
        end

        // Reset in the second SETTLE cycle aborts the transaction.
        reset_all();
        req_v = 4'b0100; req_flag = 4'b0100; req_opnd = c_opnd;
        edge_();
        req_v = '0;
        edge_();
        rst = 1'b1;
        edge_();
        rst = 1'b0;
        #3;
        chk("abort_rsp_v", 0, int'(rsp_v[0]), 0);
        chk("abort_busy", 0, int'(busy[0]), 0);
        chk("abort_m_ib1", 0, int'(ib1[0]), 0);
        chk("abort_m_iv2", 0, int'(iv2[0]), 0);
        for (int c = 0; c < 5; c++) begin
            edge_();
            #3;
            chk("abort_no_rsp", 0, int'(rsp_v[0]), 0);
        end
        edge_();
        req_v = 4'b1010;
        #3;
        chk("abort_first_grant", 0, int'(rdy[0]), 4'b0010);
        edge_();

        // Saturated load with ACK tied high, both builds side by side.
        reset_all();
        begin
            int n_acc [2];
            int last  [2];
            n_acc = '{0, 0};
            last  = '{-1, -1};
            req_v = 4'hF; req_flag = 4'h5; req_opnd = c_opnd; ack = 1'b1;
            for (int c = 0; c < 40; c++) begin
                #3;
                for (int i = 0; i < 2; i++) begin
                    if (rsp_v[i]) chk("fair_rsp_id", i, int'(rsp_id[i]), (n_acc[i] - 1) % 4);
                    if (rdy[i] != 4'b0) begin
                        chk("fair_grant", i, int'(rdy[i]), 1 << (n_acc[i] % 4));
                        if (last[i] >= 0) chk("fair_interval", i, c - last[i], m_settle[i] + 2);
                        last[i] = c;
                        n_acc[i]++;
                    end
                end
                edge_();
            end
            for (int i = 0; i < 2; i++)
                chk("fair_count", i, n_acc[i], (40 + m_settle[i] + 1) / (m_settle[i] + 2));
            ack = 1'b0;
        end

        // Random traffic, resets and backpressure against the reference.
        reset_all();
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 0; m_age[i] = 0; m_last[i] = 3; m_id[i] = 0;
            m_ib1[i] = 1'b0; m_iv2[i] = '0;
        end
        for (int c = 0; c < 3000; c++) begin
            rst      = ($urandom_range(0, 59) == 0);
            req_v    = 4'($urandom_range(0, 15));
            req_flag = 4'($urandom_range(0, 15));
            req_opnd = 12'($urandom_range(0, 4095));
            ack      = 1'($urandom_range(0, 1));
            #3;
            for (int i = 0; i < 2; i++) begin
                int  g;
                bit  ev;
                g  = pick(m_last[i], req_v);
                ev = m_busy[i] && (m_age[i] > m_settle[i]);
                chk("rnd_rdy", i, int'(rdy[i]), (!m_busy[i] && g >= 0) ? (1 << g) : 0);
                chk("rnd_busy", i, int'(busy[i]), int'(m_busy[i]));
                chk("rnd_rsp_v", i, int'(rsp_v[i]), int'(ev));
                chk("rnd_m_ib1", i, int'(ib1[i]), int'(m_ib1[i]));
                chk("rnd_m_iv2", i, int'(iv2[i]), int'(m_iv2[i]));
                if (ev) begin
                    chk("rnd_rsp_id", i, int'(rsp_id[i]), m_id[i]);
                    chk("rnd_rsp_data", i, int'(rsp_data[i]), int'({m_ib1[i], m_iv2[i]}));
                end
                if (rst) begin
                    m_busy[i] = 0; m_age[i] = 0; m_last[i] = 3;
                    m_ib1[i] = 1'b0; m_iv2[i] = '0;
                end else if (!m_busy[i]) begin
                    if (g >= 0) begin
                        m_busy[i] = 1; m_age[i] = 1; m_last[i] = g; m_id[i] = g;
                        m_ib1[i] = req_flag[g];
                        m_iv2[i] = req_opnd[3*g +: 3];
                    end
                end else if (ev && ack) begin
                    m_busy[i] = 0;
                end else begin
                    m_age[i]++;
                end
            end
            edge_();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
